// File: rtl/ids_dma_pkg.sv
// ids_dma_pkg: shared DMA state encoding, bus size constant and region map nibbles.
package ids_dma_pkg;
   typedef enum logic [2:0] {IDLE, RD, RD_DRAIN, WR, DONE} dma_state_e;
   localparam logic [3:0] SIZE_FULL  = 4'hf;
   localparam logic [3:0] REGION_BUF = 4'h2;
   localparam logic [3:0] REGION_PIM = 4'h4;
endpackage

// File: rtl/ids_dma_buf.sv
// ids_dma_buf: burst staging buffer, synchronous write, combinational read.
module ids_dma_buf
   import ids_dma_pkg::*;
#(
   parameter int BURST_LEN = 4,
   parameter int PW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [PW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [PW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);
   logic [31:0] mem_q [BURST_LEN];
   always_ff @(posedge i_clk) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end
   assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/ids_dma_master.sv
// ids_dma_master: bus-initiator DMA copying words in read-burst / write-burst pairs.
module ids_dma_master
   import ids_dma_pkg::*;
#(
   parameter int BURST_LEN = 4,
   parameter int LEN_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [31:0]      i_src_addr,
   input  logic [31:0]      i_dst_addr,
   input  logic [LEN_W-1:0] i_len,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_req,
   input  logic             i_gnt,
   output logic [31:0]      o_addr,
   output logic             o_write,
   output logic             o_read,
   output logic [3:0]       o_size,
   output logic [31:0]      o_wdata,
   input  logic [31:0]      i_rdata
);
   localparam int PW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int CW = $clog2(BURST_LEN + 1);
   dma_state_e       state_q, state_d;
   logic [31:0]      src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0] rem_q, rem_d, rem_next;
   logic [CW-1:0]    burst_q, burst_d, beat_q, beat_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             rd_vld_q;
   logic             rd_acc, wr_acc, beat_last;
   logic [31:0]      buf_rdata;
   function automatic logic [CW-1:0] burst_of(input logic [LEN_W-1:0] n);
      return (n < LEN_W'(BURST_LEN)) ? CW'(n) : CW'(BURST_LEN);
   endfunction
   assign rd_acc    = (state_q == RD) && i_gnt;
   assign wr_acc    = (state_q == WR) && i_gnt;
   assign beat_last = beat_q == burst_q - 1'b1;
   assign rem_next  = rem_q - 1'b1;
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      rem_d    = rem_q;
      burst_d  = burst_q;
      beat_d   = beat_q;
      rd_ptr_d = rd_vld_q ? rd_ptr_q + 1'b1 : rd_ptr_q;
      unique case (state_q)
         IDLE: if (i_start) begin
            src_d    = i_src_addr;
            dst_d    = i_dst_addr;
            rem_d    = i_len;
            burst_d  = burst_of(i_len);
            beat_d   = '0;
            rd_ptr_d = '0;
            state_d  = (i_len == '0) ? DONE : RD;
         end
         RD: if (rd_acc) begin
            src_d   = src_q + 32'd4;
            beat_d  = beat_last ? '0 : beat_q + 1'b1;
            state_d = beat_last ? RD_DRAIN : RD;
         end
         RD_DRAIN: state_d = WR;
         WR: if (wr_acc) begin
            dst_d  = dst_q + 32'd4;
            rem_d  = rem_next;
            beat_d = beat_last ? '0 : beat_q + 1'b1;
            if (beat_last) begin
               state_d  = (rem_next == '0) ? DONE : RD;
               burst_d  = burst_of(rem_next);
               rd_ptr_d = '0;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         rem_q    <= '0;
         burst_q  <= '0;
         beat_q   <= '0;
         rd_ptr_q <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         rem_q    <= rem_d;
         burst_q  <= burst_d;
         beat_q   <= beat_d;
         rd_ptr_q <= rd_ptr_d;
         rd_vld_q <= rd_acc;
      end
   end
   // read data lands one cycle after its beat; the drain state exists to catch the last one
   ids_dma_buf #(.BURST_LEN(BURST_LEN), .PW(PW)) u_buf (
      .i_clk  (i_clk),
      .i_we   (rd_vld_q),
      .i_waddr(rd_ptr_q),
      .i_wdata(i_rdata),
      .i_raddr(beat_q[PW-1:0]),
      .o_rdata(buf_rdata)
   );
   assign o_req   = (state_q == RD) || (state_q == WR);
   assign o_read  = state_q == RD;
   assign o_write = state_q == WR;
   assign o_addr  = o_read ? src_q : o_write ? dst_q : '0;
   assign o_wdata = o_write ? buf_rdata : '0;
   assign o_size  = o_req ? SIZE_FULL : '0;
   assign o_busy  = (state_q == RD) || (state_q == RD_DRAIN) || (state_q == WR);
   assign o_done  = state_q == DONE;
endmodule

// File: tb/tb_ids_dma_master.sv
// tb_ids_dma_master: randomized DMA bench against a slot-queue transfer model.
module tb_ids_dma_master;
   localparam int BL = 4;
   localparam int K_RD = 0, K_WR = 1, K_DR = 2, K_DN = 3;
   typedef struct {int kind; logic [31:0] addr; logic [31:0] data;} slot_t;
   logic        clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_gnt = 1'b0;
   logic [31:0] i_src_addr = '0, i_dst_addr = '0, i_rdata = '0;
   logic [15:0] i_len = '0;
   logic        o_busy, o_done, o_req, o_write, o_read;
   logic [31:0] o_addr, o_wdata;
   logic [3:0]  o_size;
   ids_dma_master #(.BURST_LEN(BL), .LEN_W(16)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_src_addr(i_src_addr),
      .i_dst_addr(i_dst_addr), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
      .o_req(o_req), .i_gnt(i_gnt), .o_addr(o_addr), .o_write(o_write),
      .o_read(o_read), .o_size(o_size), .o_wdata(o_wdata), .i_rdata(i_rdata)
   );
   always #5 clk = ~clk;
   int          checks = 0, failures = 0, cyc = 0, gmode = 0;
   int          start_cyc = 0, done_cyc = 0, wr_cnt = 0;
   logic        done_seen = 1'b0;
   logic        start_req = 1'b0, rst_req = 1'b0, last_rd = 1'b0;
   logic [31:0] last_addr = '0, s_src = '0, s_dst = '0;
   logic [15:0] s_len = '0;
   slot_t       slot_q[$];
   logic [31:0] rd_log[$];
   logic [31:0] wr_mem[logic [31:0]];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   function automatic void build(input logic [31:0] src, input logic [31:0] dst, input int len);
      int base = 0;
      while (base < len) begin
         int n = (len - base < BL) ? len - base : BL;
         for (int k = 0; k < n; k++) slot_q.push_back('{K_RD, src + 32'(4 * (base + k)), 32'h0});
         slot_q.push_back('{K_DR, 32'h0, 32'h0});
         for (int k = 0; k < n; k++)
            slot_q.push_back('{K_WR, dst + 32'(4 * (base + k)), (src + 32'(4 * (base + k))) ^ 32'hA5A5_A5A5});
         base += n;
      end
      slot_q.push_back('{K_DN, 32'h0, 32'h0});
   endfunction
   // one cycle: compare this cycle's outputs, then choose inputs for the next edge
   task automatic tick();
      logic [72:0] exp_v, act_v;
      logic        idle_now, g;
      @(negedge clk);
      cyc++;
      act_v = {o_req, o_read, o_write, o_size, o_addr, o_wdata, o_busy, o_done};
      exp_v = '0;
      if (slot_q.size() != 0)
         case (slot_q[0].kind)
            K_RD:    exp_v = {3'b110, 4'hf, slot_q[0].addr, 32'h0, 2'b10};
            K_WR:    exp_v = {3'b101, 4'hf, slot_q[0].addr, slot_q[0].data, 2'b10};
            K_DR:    exp_v = {3'b000, 4'h0, 64'h0, 2'b10};
            default: exp_v = {71'h0, 2'b01};
         endcase
      checks++;
      if (act_v !== exp_v) begin
         failures++;
         $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
      end
      if (o_done) begin
         done_cyc  = cyc;
         done_seen = 1'b1;
      end
      idle_now = slot_q.size() == 0;
      g = (gmode == 0) ? 1'b1 : (gmode == 1) ? ($urandom_range(0, 3) != 0) : (cyc % 4 == 0 || cyc % 4 == 3);
      i_gnt   = g;
      i_rdata = last_rd ? last_addr ^ 32'hA5A5_A5A5 : $urandom;
      last_rd = 1'b0;
      if (slot_q.size() != 0) begin
         if (slot_q[0].kind == K_RD && g) begin
            last_rd   = 1'b1;
            last_addr = slot_q[0].addr;
            rd_log.push_back(o_addr);
            void'(slot_q.pop_front());
         end else if (slot_q[0].kind == K_WR && g) begin
            wr_cnt++;
            wr_mem[o_addr] = o_wdata;
            void'(slot_q.pop_front());
         end else if (slot_q[0].kind == K_DR || slot_q[0].kind == K_DN)
            void'(slot_q.pop_front());
      end
      i_start    = start_req;
      i_src_addr = start_req ? s_src : $urandom;
      i_dst_addr = start_req ? s_dst : $urandom;
      i_len      = start_req ? s_len : 16'($urandom);
      if (start_req && idle_now && !rst_req) begin
         build(s_src, s_dst, int'(s_len));
         start_cyc = cyc;
      end
      start_req = 1'b0;
      i_rst     = rst_req;
      if (rst_req) begin
         slot_q.delete();
         last_rd = 1'b0;
      end
      rst_req = 1'b0;
   endtask
   task automatic begin_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
      s_src = src;
      s_dst = dst;
      s_len = len;
      start_req = 1'b1;
      wr_cnt = 0;
      wr_mem.delete();
      rd_log.delete();
      done_seen = 1'b0;
      tick();
   endtask
   task automatic finish_xfer();
      for (int i = 0; i < 3000 && slot_q.size() != 0; i++) tick();
      chk("xfer_timeout", 32'(slot_q.size()), 32'h0);
      tick();
   endtask
   initial begin
      rst_req = 1'b1;
      tick();
      tick();
      chk("reset_busy", {31'h0, o_busy}, 32'h0);
      gmode = 0;
      begin_xfer(32'h2000_0000, 32'h4000_0000, 16'd4);
      finish_xfer();
      chk("basic_done_latency", 32'(done_cyc - start_cyc), 32'd10);
      chk("basic_wr_cnt", 32'(wr_cnt), 32'd4);
      chk("basic_last_data", wr_mem.exists(32'h4000_000C) ? wr_mem[32'h4000_000C] : 32'hDEAD_BEEF, 32'h85A5_A5A9);
      chk("basic_busy_after", {31'h0, o_busy}, 32'h0);
      begin_xfer(32'h2000_0040, 32'h4000_0100, 16'd6);
      finish_xfer();
      chk("partial_wr_cnt", 32'(wr_cnt), 32'd6);
      chk("partial_last_addr", {31'h0, wr_mem.exists(32'h4000_0114)}, 32'h1);
      gmode = 2;
      begin_xfer(32'h2000_1000, 32'h4000_2000, 16'd5);
      finish_xfer();
      chk("stall_wr_cnt", 32'(wr_cnt), 32'd5);
      chk("stall_data", wr_mem.exists(32'h4000_2010) ? wr_mem[32'h4000_2010] : 32'h0, 32'h2000_1010 ^ 32'hA5A5_A5A5);
      gmode = 0;
      begin_xfer(32'h2000_0000, 32'h4000_0000, 16'd0);
      finish_xfer();
      chk("zero_len_done", {31'h0, done_seen}, 32'h1);
      chk("zero_len_wr_cnt", 32'(wr_cnt), 32'd0);
      begin_xfer(32'h2000_0200, 32'h4000_0300, 16'd4);
      tick();
      tick();
      s_src = 32'h2BAD_0000;
      s_dst = 32'h4BAD_0000;
      s_len = 16'd9;
      start_req = 1'b1;
      tick();
      finish_xfer();
      chk("busy_start_wr_cnt", 32'(wr_cnt), 32'd4);
      chk("busy_start_data", wr_mem.exists(32'h4000_0300) ? wr_mem[32'h4000_0300] : 32'h0, 32'h2000_0200 ^ 32'hA5A5_A5A5);
      begin_xfer(32'h2000_0400, 32'h4000_0500, 16'd8);
      for (int i = 0; i < 100 && !(slot_q.size() != 0 && slot_q[0].kind == K_WR); i++) tick();
      tick();
      rst_req = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      chk("rst_no_done", {31'h0, done_seen}, 32'h0);
      chk("rst_req_low", {31'h0, o_req}, 32'h0);
      begin_xfer(32'h2000_0600, 32'h4000_0700, 16'd3);
      finish_xfer();
      chk("post_rst_wr_cnt", 32'(wr_cnt), 32'd3);
      begin_xfer(32'hFFFF_FFF8, 32'h4000_0000, 16'd4);
      finish_xfer();
      chk("wrap_rd2", rd_log.size() > 2 ? rd_log[2] : 32'hFFFF_FFFF, 32'h0000_0000);
      chk("wrap_rd3", rd_log.size() > 3 ? rd_log[3] : 32'hFFFF_FFFF, 32'h0000_0004);
      gmode = 1;
      for (int t = 0; t < 25; t++) begin
         logic [15:0] n = 16'($urandom_range(0, 13));
         begin_xfer({4'h2, $urandom_range(0, 255), 20'h0} & 32'hFFFF_FFFC, {4'h4, 28'($urandom)} & 32'hFFFF_FFFC, n);
         if ($urandom_range(0, 1) == 1) begin
            tick();
            s_src = $urandom;
            s_len = 16'($urandom_range(1, 20));
            start_req = 1'b1;
         end
         finish_xfer();
         chk("rand_wr_cnt", 32'(wr_cnt), 32'(n));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
